// File: rtl/probe_mux_n.sv
// Arbitrates NUM_IN probe channels into one registered uplink word.
// Round-robin or fixed-priority selection with a valid/ack handshake.
module probe_mux_n #(
    parameter int NUM_IN   = 4,
    parameter int DATA_W   = 32,
    parameter int ARB_MODE = 0,
    parameter int IW       = 4
) (
    input  logic                     UCLK,
    input  logic                     URST,
    input  logic [NUM_IN*DATA_W-1:0] DATAUP_IN,
    input  logic [NUM_IN-1:0]        DATAVALID_IN,
    input  logic [NUM_IN-1:0]        DELAY_IN,
    output logic [NUM_IN-1:0]        ACK_IN,
    output logic [DATA_W-1:0]        DATAUP,
    output logic                     DATAVALID,
    output logic                     DELAY,
    input  logic                     ACK,
    output logic [IW-1:0]            CHAN
);

    logic [DATA_W-1:0] dataup_q, dataup_d;
    logic              valid_q, valid_d;
    logic [IW-1:0]     chan_q, chan_d;
    logic [IW-1:0]     ptr_q, ptr_d;

    logic                     load_en;
    logic                     found;
    logic [IW-1:0]            win;
    logic [DATA_W-1:0]        win_word;
    logic [NUM_IN-1:0]        vshift;
    logic [NUM_IN*DATA_W-1:0] wshift;

    always_comb begin
        int idx;
        load_en  = ACK | ~valid_q;
        found    = 1'b0;
        win      = '0;
        win_word = '0;
        vshift   = '0;
        wshift   = '0;
        idx      = 0;
        for (int k = 0; k < NUM_IN; k++) begin
            if (ARB_MODE == 0) begin
                idx = int'(ptr_q) + k;
                if (idx >= NUM_IN) idx = idx - NUM_IN;
            end else begin
                idx = k;
            end
            vshift = DATAVALID_IN >> idx;
            if (!found && vshift[0]) begin
                found    = 1'b1;
                win      = IW'(idx);
                wshift   = DATAUP_IN >> (idx * DATA_W);
                win_word = wshift[DATA_W-1:0];
            end
        end
        // Nothing is granted while reset holds the block
        if (URST) found = 1'b0;
    end

    always_comb begin
        dataup_d = dataup_q;
        valid_d  = valid_q;
        chan_d   = chan_q;
        ptr_d    = ptr_q;
        if (load_en) begin
            if (found) begin
                dataup_d = win_word;
                chan_d   = win;
                valid_d  = 1'b1;
                if (ARB_MODE == 0) begin
                    ptr_d = (win == IW'(NUM_IN - 1)) ? '0 : win + 1'b1;
                end
            end else begin
                valid_d = 1'b0;
            end
        end
    end

    always_ff @(posedge UCLK or posedge URST) begin
        if (URST) begin
            dataup_q <= '0;
            valid_q  <= 1'b0;
            chan_q   <= '0;
            ptr_q    <= '0;
        end else begin
            dataup_q <= dataup_d;
            valid_q  <= valid_d;
            chan_q   <= chan_d;
            ptr_q    <= ptr_d;
        end
    end

    assign ACK_IN    = (found && load_en) ? (NUM_IN'(1) << win) : '0;
    assign DATAUP    = dataup_q;
    assign DATAVALID = valid_q;
    assign CHAN      = chan_q;
    assign DELAY     = (|DELAY_IN) | valid_q;

endmodule
